// File: rtl/divisor_pkg.sv
// Shared types and sizing for the divisor binary-to-BCD converter.
// The accumulator holds one more digit than is presented, so values above 9999 wrap mod 10000.
package divisor_pkg;
  localparam int IN_W       = 16;
  localparam int BCD_DIGITS = 4;
  localparam int BCD_ACC_W  = 20;
  localparam int ACC_DIGITS = BCD_ACC_W / 4;
  localparam int CONV_ITERS = 16;
  localparam int CNT_W      = 5;

  typedef enum logic {
    DONE    = 1'b0,
    CONVERT = 1'b1
  } state_t;
endpackage

// File: rtl/divisor_if.sv
// Value-in / digits-out bundle of the divisor converter.
// The master drives the binary value; the slave returns BCD digits and listo.
interface divisor_if;
  import divisor_pkg::*;

  logic [IN_W-1:0] numero_input;
  logic [3:0]      unidades_output;
  logic [3:0]      decenas_output;
  logic [3:0]      centenas_output;
  logic [3:0]      millares_output;
  logic            listo;

  modport master (
    output numero_input,
    input  unidades_output, decenas_output, centenas_output, millares_output, listo
  );

  modport slave (
    input  numero_input,
    output unidades_output, decenas_output, centenas_output, millares_output, listo
  );
endinterface

// File: rtl/divisor_bcd_adjust.sv
// Double-dabble digit correction: add 3 to any BCD digit of 5 or more before the shift.
module bcd_adjust (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);
  assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;
endmodule

// File: rtl/divisor.sv
// Sequential 16-bit binary-to-BCD converter (shift-and-add-3), re-converting whenever the input changes.
// listo is combinational so a changed input is never reported against stale digits.
module divisor
  import divisor_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  divisor_if.slave bus
);
  state_t                  r_state, w_next;
  logic [IN_W-1:0]         r_captured;
  logic [IN_W-1:0]         r_bin;
  logic [BCD_ACC_W-1:0]    r_bcd;
  logic [BCD_ACC_W-1:0]    w_bcd_adj;
  logic [BCD_ACC_W+IN_W-1:0] w_shifted;
  logic [CNT_W-1:0]        r_cnt;
  logic [3:0]              r_unid, r_dec, r_cen, r_mil;
  logic                    w_change, w_last, w_load;

  for (genvar g = 0; g < ACC_DIGITS; g++) begin : g_adj
    bcd_adjust u_adj (
      .i_digit (r_bcd[4*g +: 4]),
      .o_digit (w_bcd_adj[4*g +: 4])
    );
  end

  assign w_shifted = {w_bcd_adj, r_bin} << 1;
  assign w_change  = (bus.numero_input != r_captured);
  assign w_last    = (r_cnt == CNT_W'(CONV_ITERS - 1));
  assign w_load    = (r_state == DONE) && w_change;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= DONE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      DONE:    if (w_change) w_next = CONVERT;
      CONVERT: if (w_last)   w_next = DONE;
      default: w_next = DONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_captured <= '0;
      r_cnt      <= '0;
      r_unid     <= '0;
      r_dec      <= '0;
      r_cen      <= '0;
      r_mil      <= '0;
    end else if (w_load) begin
      r_captured <= bus.numero_input;
      r_cnt      <= '0;
    end else if (r_state == CONVERT) begin
      r_cnt <= r_cnt + 1'b1;
      // Final iteration: take the digits straight from the shifted value; the 5th digit is dropped.
      if (w_last) begin
        r_unid <= w_shifted[IN_W      +: 4];
        r_dec  <= w_shifted[IN_W + 4  +: 4];
        r_cen  <= w_shifted[IN_W + 8  +: 4];
        r_mil  <= w_shifted[IN_W + 12 +: 4];
      end
    end
  end

  // Shift register is pure datapath and is always reloaded before use.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_bin <= bus.numero_input;
      r_bcd <= '0;
    end else if (r_state == CONVERT) begin
      {r_bcd, r_bin} <= w_shifted;
    end
  end

  assign bus.unidades_output = r_unid;
  assign bus.decenas_output  = r_dec;
  assign bus.centenas_output = r_cen;
  assign bus.millares_output = r_mil;
  assign bus.listo           = (r_state == DONE) && !w_change;
endmodule

// File: tb/tb_divisor.sv
// Randomized self-checking bench for divisor against a decimal-arithmetic reference model.
module tb_divisor;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  divisor_if bus ();

  divisor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  int unsigned cur_v = 0;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packed digits {M,C,D,U}; printed in hex they read as the decimal value.
  function automatic int unsigned model_bcd(input int unsigned v);
    int unsigned r;
    r = v % 10000;
    return ((r / 1000) << 12) | (((r / 100) % 10) << 8) | (((r / 10) % 10) << 4) | (r % 10);
  endfunction

  function automatic int unsigned dut_bcd();
    return {16'd0, bus.millares_output, bus.centenas_output, bus.decenas_output, bus.unidades_output};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until listo rises, bounded; a timeout shows up as a wrong latency.
  task automatic wait_listo(input int unsigned hold_v, output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == 8) check("hold_digits", dut_bcd(), model_bcd(hold_v));
      n = i;
      if (bus.listo) break;
    end
  endtask

  task automatic convert(input int unsigned v);
    int n;
    bus.numero_input = 16'(v);
    #1;
    check("listo_drop", bus.listo, 0);
    wait_listo(cur_v, n);
    check("latency", n, 17);
    check("digits", dut_bcd(), model_bcd(v));
    cur_v = v;
  endtask

  initial begin
    int n;
    int unsigned v;
    bus.numero_input = '0;
    rst = 1'b0;
    #12;
    check("rst_digits", dut_bcd(), 0);
    check("rst_listo", bus.listo, 1);
    @(negedge clk) rst = 1'b1;
    repeat (3) step();
    check("idle_listo", bus.listo, 1);
    check("idle_digits", dut_bcd(), 0);

    convert(1234);
    convert(5678);
    convert(910);
    convert(65535);
    convert(9999);

    bus.numero_input = 16'd9999;
    repeat (3) step();
    check("same_listo", bus.listo, 1);
    check("same_digits", dut_bcd(), model_bcd(9999));

    // Input change partway through a conversion
    bus.numero_input = 16'd1234;
    repeat (6) step();
    bus.numero_input = 16'd4321;
    repeat (11) step();
    check("mid_first_digits", dut_bcd(), model_bcd(1234));
    check("mid_first_listo", bus.listo, 0);
    n = 17;
    for (int i = 0; i < 30; i++) begin
      if (bus.listo) break;
      step();
      n++;
    end
    check("mid_latency", n, 34);
    check("mid_digits", dut_bcd(), model_bcd(4321));
    cur_v = 4321;

    // Asynchronous reset during a conversion
    bus.numero_input = 16'd8765;
    repeat (8) step();
    check("pre_rst_hold", dut_bcd(), model_bcd(4321));
    rst = 1'b0;
    #1;
    check("async_rst_digits", dut_bcd(), 0);
    check("async_rst_listo", bus.listo, 0);
    @(negedge clk) rst = 1'b1;
    cur_v = 0;
    wait_listo(0, n);
    check("rst_restart_latency", n, 17);
    check("rst_restart_digits", dut_bcd(), model_bcd(8765));
    cur_v = 8765;
    step();

    for (int k = 0; k < 12; k++) begin
      v = $urandom_range(0, 65535);
      if (v == cur_v) v = (v + 1) % 65536;
      convert(v);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
